// File: rtl/cache_mem_ctrl.sv
// cache_mem_ctrl: icache/dcache arbiter and RAM request driver.
// Optional perf counters enabled by CACHE_MEM_CTRL_PERF_EN.
module cache_mem_ctrl #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [ADDR_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [ADDR_W-1:0] dstore,
  output logic              dwait,
  output logic [ADDR_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [ADDR_W-1:0] ramstore,
  input  logic [ADDR_W-1:0] ramload,
  input  logic [1:0]        ramstate
`ifdef CACHE_MEM_CTRL_PERF_EN
  ,
  output logic [31:0]       icnt,
  output logic [31:0]       dcnt,
  output logic [15:0]       errcnt
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DSERV = 2'd1,
    ISERV = 2'd2,
    DLOCK = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            d_done, i_done;
  logic            access;
  logic            d_req;

  assign iload  = ramload;
  assign dload  = ramload;
  assign access = (ramstate == RAM_ACCESS);
  assign d_req  = dREN | dWEN;

  // State and starvation counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Arbitration, RAM request drive and cache handshakes.
  always_comb begin
    state_d  = state_q;
    iwait    = 1'b1;
    dwait    = 1'b1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    d_done   = 1'b0;
    i_done   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (d_req && !(iREN && starve_q == LIM))
          state_d = DSERV;
        else if (iREN)
          state_d = ISERV;
      end
      DSERV, DLOCK: begin
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          ramaddr = daddr;
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          if (access) begin
            dwait   = 1'b0;
            d_done  = 1'b1;
            state_d = daddr[2] ? IDLE : DLOCK;
          end
        end
      end
      ISERV: begin
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (access) begin
            iwait   = 1'b0;
            i_done  = 1'b1;
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  // Consecutive dcache words served while the icache waits.
  always_comb begin
    starve_d = starve_q;
    if (!iREN || i_done)
      starve_d = '0;
    else if (d_done && starve_q != LIM)
      starve_d = starve_q + SW'(1);
  end

`ifdef CACHE_MEM_CTRL_PERF_EN
  logic [31:0] icnt_q, icnt_d;
  logic [31:0] dcnt_q, dcnt_d;
  logic [15:0] err_q, err_d;

  assign icnt   = icnt_q;
  assign dcnt   = dcnt_q;
  assign errcnt = err_q;

  // Saturating completion and error counters.
  always_comb begin
    icnt_d = icnt_q;
    dcnt_d = dcnt_q;
    err_d  = err_q;
    if (i_done && icnt_q != '1)
      icnt_d = icnt_q + 32'd1;
    if (d_done && dcnt_q != '1)
      dcnt_d = dcnt_q + 32'd1;
    if ((ramREN || ramWEN) && ramstate == RAM_ERROR && err_q != '1)
      err_d = err_q + 16'd1;
  end

  // Perf counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icnt_q <= '0;
      dcnt_q <= '0;
      err_q  <= '0;
    end else begin
      icnt_q <= icnt_d;
      dcnt_q <= dcnt_d;
      err_q  <= err_d;
    end
  end
`endif

endmodule

// File: doc/cache_mem_ctrl.md
Name: cache_mem_ctrl

Overview:
- Memory-side responder for the instruction and data cache miss/writeback protocol; it sits between the icache/dcache and the single-ported RAM.
- Arbitrates word-level requests from both caches and drives one RAM request per cycle.
- Returns per-cache wait/load handshakes to the requesting cache.
- Locks the RAM to the dcache for a full two-word block transfer (load or writeback pair) and enforces bounded icache starvation.

Parameters:
- STARVE_LIMIT, 4: max consecutive dcache word grants while iREN is pending before one icache word is forced.
- ADDR_W, 32: address/data width.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  icache read request
- iaddr  in  ADDR_W  icache word address
- iwait  out  1  high = icache must hold request
- iload  out  ADDR_W  instruction word returned
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  ADDR_W  dcache word address; bit 2 = word select within block
- dstore  in  ADDR_W  dcache write data
- dwait  out  1  high = dcache must hold request
- dload  out  ADDR_W  data word returned
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  ADDR_W  RAM write data
- ramload  in  ADDR_W  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- States: IDLE, DSERV, ISERV, DLOCK.
- Reset and IDLE outputs: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, starve counter=0.
- iload and dload are combinational copies of ramload in all states; they are meaningful only while the matching wait signal is low.
- Arbitration (IDLE):
  - dREN|dWEN goes to DSERV unless iREN is set and starve counter == STARVE_LIMIT; in that case go to ISERV.
  - Otherwise iREN goes to ISERV.
  - No request: stay in IDLE.
- DSERV/DLOCK:
  - ramaddr=daddr.
  - dWEN: ramWEN=1, ramstore=dstore. dWEN wins if dREN and dWEN are both set. Otherwise ramREN=1.
  - dwait=0 combinationally in the cycle ramstate==ACCESS.
  - On that ACCESS: if daddr[2]==0, go to DLOCK (second word pending). If daddr[2]==1, return to IDLE.
  - Starve counter increments per completed dcache word while iREN is pending, saturating at STARVE_LIMIT. Clear it when iREN=0.
- DLOCK: the dcache keeps the grant regardless of iREN or the starve counter. If dREN and dWEN both drop, return to IDLE with no RAM access.
- ISERV:
  - ramREN=1, ramaddr=iaddr.
  - iwait=0 in the ACCESS cycle, then return to IDLE and clear the starve counter.
  - If iREN drops before ACCESS, go to IDLE.
- A forced icache grant never splits a locked block: the starve check happens only in IDLE.
- ramstate BUSY or FREE: hold the current request and keep wait high.
- ramstate ERROR: hold the request and keep wait high, so the transfer retries. No state change.
- Latency: the grant decision is registered, so the first RAM request follows one cycle after the cache request. Zero-wait RAM gives one word per cycle after that.
- Asynchronous reset mid-transfer: drop RAM enables immediately and lose the lock. The cache re-issues its request.

Optional Feature:
- Macro: CACHE_MEM_CTRL_PERF_EN.
- Defined: adds outputs icnt[31:0], dcnt[31:0] and errcnt[15:0].
  - icnt and dcnt count completed words for each cache; errcnt counts ERROR cycles.
  - Each counter resets to 0 and saturates at its maximum value.
- Undefined: these ports and counters are absent, with no other behavioural difference.

Test Plan:
- Reset with dREN=1 asserted → iwait=dwait=1, ramREN=0. After release, ramREN=1 at cycle 1.
- dREN, daddr=0x100 then 0x104 with ramstate ACCESS each cycle, iREN=1 throughout → both dcache words complete back-to-back. No icache grant between them. dload=ramload.
- dWEN=1, dREN=1, daddr=0x200, dstore=0xDEADBEEF → ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
- With STARVE_LIMIT=4 and continuous dcache blocks while iREN=1, iaddr=0x40 → after the 4th dcache word, the next IDLE grants the icache. iwait pulses low once with iload=ramload.
- ramstate held BUSY 3 cycles, then ERROR 2 cycles, then ACCESS during an icache read → iwait stays high 5 cycles and goes low on the ACCESS cycle. With perf enabled, errcnt=2 and icnt=1.
- Assert nRST low while in DLOCK → RAM enables drop the same cycle. Next grant after release is re-arbitrated; an iREN-only request is granted.
